// File: rtl/cordic_vectoring.sv
// cordic_vectoring
//   Iterative vectoring-mode CORDIC. It converts a signed Cartesian vector
//   (x_in, y_in) into a magnitude and an atan2 phase. The phase uses the
//   fixed-point format radians * 2^FRAC_BITS, signed ANGLE_WIDTH bits.
//
//   Build option: CORDIC_VEC_GAIN_COMP_EN
//     defined   : an extra SCALE cycle removes the CORDIC gain, so
//                 magnitude ~= |v|. Latency is ITERATIONS+3.
//     undefined : magnitude = K_N*|v| (raw gain of about 1.6468).
//                 Latency is ITERATIONS+2.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high
//   start     in   request; sampled only in IDLE
//   x_in      in   [WIDTH-1:0]     signed X, captured on the accepting edge
//   y_in      in   [WIDTH-1:0]     signed Y, captured on the accepting edge
//   busy      out  high from the accepting edge until the done edge
//   done      out  one-cycle pulse; results are valid from this cycle on
//   magnitude out  [WIDTH:0]       unsigned vector length
//   phase     out  [ANGLE_WIDTH-1:0] signed atan2(y,x), in (-pi,+pi]
//   zero_vec  out  input was (0,0); valid with done
module cordic_vectoring #(
    parameter int WIDTH       = 16,
    parameter int ITERATIONS  = 15,
    parameter int ANGLE_WIDTH = 32,
    parameter int FRAC_BITS   = ANGLE_WIDTH - 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH-1:0]       x_in,
    input  logic [WIDTH-1:0]       y_in,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH:0]         magnitude,
    output logic [ANGLE_WIDTH-1:0] phase,
    output logic                   zero_vec
);

    // Two guard bits: one absorbs the negation of the most-negative input,
    // and one absorbs the CORDIC gain growth.
    localparam int  DW     = WIDTH + 2;
    localparam real PI_R   = 3.14159265358979323846;
    localparam real ASCALE = 2.0 ** FRAC_BITS;
    localparam logic signed [ANGLE_WIDTH-1:0] PI = ANGLE_WIDTH'($rtoi(PI_R * ASCALE));

    function automatic logic [ITERATIONS*ANGLE_WIDTH-1:0] atan_table();
        logic [ITERATIONS*ANGLE_WIDTH-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < ITERATIONS; i++) begin
            t[i*ANGLE_WIDTH +: ANGLE_WIDTH] =
                ANGLE_WIDTH'($rtoi($atan(1.0 / (2.0 ** i)) * ASCALE));
        end
        return t;
    endfunction

    localparam logic [ITERATIONS*ANGLE_WIDTH-1:0] ATAN_TABLE = atan_table();

`ifdef CORDIC_VEC_GAIN_COMP_EN
    function automatic int gain_const();
        real k;
        k = 1.0;
        for (int unsigned i = 0; i < ITERATIONS; i++) begin
            k = k * $sqrt(1.0 + 1.0 / (4.0 ** i));
        end
        return $rtoi((2.0 ** (WIDTH - 2)) / k);
    endfunction

    localparam int GAIN = gain_const();
    localparam int PW   = DW + WIDTH;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREROT,
        S_ITER,
        S_SCALE,
        S_FINISH
    } state_t;

    state_t                        r_state;
    logic signed [DW-1:0]          r_x;
    logic signed [DW-1:0]          r_y;
    logic signed [ANGLE_WIDTH-1:0] r_z;
    logic [4:0]                    r_iter;
    logic                          r_is_zero;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_zero_vec;
    logic [WIDTH:0]                r_mag;
    logic [ANGLE_WIDTH-1:0]        r_phase;

    logic signed [DW-1:0]          w_xs;
    logic signed [DW-1:0]          w_ys;
    logic signed [ANGLE_WIDTH-1:0] w_atan;
    logic signed [ANGLE_WIDTH-1:0] w_phase_sat;

    always_comb begin
        w_xs        = r_x >>> r_iter;
        w_ys        = r_y >>> r_iter;
        w_atan      = ATAN_TABLE[int'(r_iter)*ANGLE_WIDTH +: ANGLE_WIDTH];
        // Residual overshoot past +PI (e.g. for x<0, y=0) folds back to +PI.
        w_phase_sat = (r_z > PI) ? PI : r_z;
    end

`ifdef CORDIC_VEC_GAIN_COMP_EN
    logic signed [PW-1:0] w_prod;
    assign w_prod = PW'(r_x) * PW'(GAIN);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_iter     <= '0;
            r_is_zero  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_zero_vec <= 1'b0;
            r_mag      <= '0;
            r_phase    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_x       <= DW'($signed(x_in));
                        r_y       <= DW'($signed(y_in));
                        r_is_zero <= (x_in == '0) && (y_in == '0);
                        r_busy    <= 1'b1;
                        r_state   <= S_PREROT;
                    end
                end
                S_PREROT: begin
                    // Fold the left half-plane into the right half-plane and
                    // preload z with +/-PI. Here y still holds its original sign.
                    r_iter <= '0;
                    if (r_x[DW-1]) begin
                        r_x <= -r_x;
                        r_y <= -r_y;
                        r_z <= r_y[DW-1] ? -PI : PI;
                    end else begin
                        r_z <= '0;
                    end
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    if (!r_y[DW-1]) begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + w_atan;
                    end else begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - w_atan;
                    end
                    if (r_iter == 5'(ITERATIONS - 1)) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                        r_state <= S_SCALE;
`else
                        r_state <= S_FINISH;
`endif
                    end else begin
                        r_iter <= r_iter + 5'd1;
                    end
                end
`ifdef CORDIC_VEC_GAIN_COMP_EN
                S_SCALE: begin
                    r_x     <= DW'(w_prod >>> (WIDTH - 2));
                    r_state <= S_FINISH;
                end
`endif
                S_FINISH: begin
                    r_mag      <= r_is_zero ? '0 : r_x[WIDTH:0];
                    r_phase    <= r_is_zero ? '0 : w_phase_sat;
                    r_zero_vec <= r_is_zero;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign magnitude = r_mag;
    assign phase     = r_phase;
    assign zero_vec  = r_zero_vec;

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring
//   Scoreboard bench for cordic_vectoring. When a request is issued, the
//   expected magnitude, phase, zero flag and latency are computed with plain
//   real arithmetic ($atan2, $sqrt) and queued. A monitor pops and compares
//   the queued values on every done pulse.
module tb_cordic_vectoring;

    localparam int  WIDTH       = 16;
    localparam int  ITERATIONS  = 15;
    localparam int  ANGLE_WIDTH = 32;
    localparam int  FRAC_BITS   = ANGLE_WIDTH - 3;
    localparam real ASCALE      = 2.0 ** FRAC_BITS;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam bit     COMP = 1'b1;
    localparam longint LAT  = ITERATIONS + 3;
`else
    localparam bit     COMP = 1'b0;
    localparam longint LAT  = ITERATIONS + 2;
`endif
    localparam longint PT  = 65536;   // directed phase tolerance (LSB)
    localparam longint MT  = 8;       // directed magnitude tolerance (LSB)
    localparam longint RPT = 131072;  // random vectors accumulate more truncation error
    localparam longint RMT = 16;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   start = 1'b0;
    logic [WIDTH-1:0]       x_in  = '0;
    logic [WIDTH-1:0]       y_in  = '0;
    logic                   busy;
    logic                   done;
    logic [WIDTH:0]         magnitude;
    logic [ANGLE_WIDTH-1:0] phase;
    logic                   zero_vec;

    cordic_vectoring #(
        .WIDTH       (WIDTH),
        .ITERATIONS  (ITERATIONS),
        .ANGLE_WIDTH (ANGLE_WIDTH),
        .FRAC_BITS   (FRAC_BITS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .magnitude (magnitude),
        .phase     (phase),
        .zero_vec  (zero_vec)
    );

    always #5 clock = ~clock;

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int     x;
        int     y;
        longint ph;
        longint mag;
        bit     zero;
        longint acc;
        longint ptol;
        longint mtol;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   done_seen = 0;
    real  kn;

    task automatic check(input string name, input longint act, input longint exp, input longint tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic push_exp(input int x, input int y, input longint ptol, input longint mtol);
        exp_t e;
        real  r;
        r      = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        e.x    = x;
        e.y    = y;
        e.zero = (x == 0 && y == 0);
        e.mag  = e.zero ? 0 : longint'(COMP ? r : r * kn);
        e.ph   = e.zero ? 0 : longint'($atan2(real'(y), real'(x)) * ASCALE);
        e.acc  = cyc + 1;
        e.ptol = ptol;
        e.mtol = mtol;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending request");
                end else begin
                    e = sb.pop_front();
                    check($sformatf("phase(%0d,%0d)", e.x, e.y), longint'($signed(phase)), e.ph, e.ptol);
                    check($sformatf("magnitude(%0d,%0d)", e.x, e.y), longint'(magnitude), e.mag, e.mtol);
                    check($sformatf("zero_vec(%0d,%0d)", e.x, e.y), longint'(zero_vec), longint'(e.zero), 0);
                    check($sformatf("latency(%0d,%0d)", e.x, e.y), cyc - e.acc, LAT, 0);
                    check("busy_low_with_done", longint'(busy), 0, 0);
                end
            end
        end
    endtask

    // Called at a negedge; issues once the block is idle (also in a done cycle).
    task automatic issue(input int x, input int y, input longint ptol, input longint mtol);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: got busy=1 expected idle within 100 cycles");
            return;
        end
        start = 1'b1;
        x_in  = WIDTH'(x);
        y_in  = WIDTH'(y);
        push_exp(x, y, ptol, mtol);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},      longint'(busy),      0, 0);
        check({tag, "_done"},      longint'(done),      0, 0);
        check({tag, "_magnitude"}, longint'(magnitude), 0, 0);
        check({tag, "_phase"},     longint'(phase),     0, 0);
        check({tag, "_zero_vec"},  longint'(zero_vec),  0, 0);
    endtask

    initial begin
        int n;
        int rx;
        int ry;
        int seen;
        kn = 1.0;
        for (int i = 0; i < ITERATIONS; i++) kn = kn * $sqrt(1.0 + 1.0 / (4.0 ** i));

        fork
            monitor();
        join_none

        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        issue(16384, 0, PT, MT);
        issue(10000, 10000, PT, MT);
        issue(-16384, 0, PT, MT);
        issue(0, -16384, PT, MT);
        issue(-32768, -32768, PT, MT);
        issue(-32768, 0, PT, MT);
        issue(0, 0, PT, MT);
        // Only a 5-LSB vector: the integer datapath resolves its angle coarsely.
        issue(0, 5, longint'(0.25 * ASCALE), MT);

        // Hold start (with new data) while busy: it is ignored until the done
        // cycle, where it is accepted back-to-back.
        issue(12000, -9000, PT, MT);
        start = 1'b1;
        x_in  = WIDTH'(-7000);
        y_in  = WIDTH'(20000);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        push_exp(-7000, 20000, PT, MT);
        @(negedge clock);
        start = 1'b0;

        for (int k = 0; k < 12; k++) begin
            do begin
                rx = int'($urandom_range(65535)) - 32768;
                ry = int'($urandom_range(65535)) - 32768;
            end while (real'(rx) * real'(rx) + real'(ry) * real'(ry) < 16384.0 * 16384.0);
            issue(rx, ry, RPT, RMT);
        end
        drain();

        // Abort mid-iteration: this lands in ITER with iteration index 7.
        issue(20000, 15000, PT, MT);
        repeat (8) @(negedge clock);
        reset = 1'b1;
        sb.delete();
        #1;
        check_outputs_zero("abort");
        @(negedge clock);
        reset = 1'b0;
        seen = done_seen;
        repeat (30) @(negedge clock);
        check("no_done_after_abort", longint'(done_seen), longint'(seen), 0);
        check_outputs_zero("post_abort");

        issue(-20000, 5000, PT, MT);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
